ins_fetch_cache: RTL and testbench

- Instruction-side initiator of the fetch handshake served by the memory controller (Memctrl).
- Owns the PC and a direct-mapped instruction cache.
- On a miss, requests one 32-bit word from the memory controller and waits for the one-cycle ok pulse.
- Delivers one instruction per cycle to the decode/issue stage on hits; redirects on jump/flush from the ROB.

---
 rtl/ins_fetch_cache.sv | 137 +++++++++++++
 tb/tb_ins_fetch_cache.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/ins_fetch_cache.sv
// rtl/ins_fetch_cache.sv - PC owner and direct-mapped instruction cache.
// Fills one word per miss from the memory controller; emits one instruction per cycle on hits.
module ins_fetch_cache #(
  parameter int          INDEX_BITS = 6,
  parameter logic [31:0] RESET_PC   = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rdy,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ok,
  input  logic [31:0] mem_ins,
  input  logic        stall_in,
  input  logic        jump_en,
  input  logic [31:0] jump_pc,
  output logic        ins_valid,
  output logic [31:0] ins,
  output logic [31:0] ins_pc
);

  localparam int LINES    = 1 << INDEX_BITS;
  localparam int TAG_BITS = 30 - INDEX_BITS;

  typedef enum logic [1:0] {
    LOOKUP    = 2'd0,
    MISS_WAIT = 2'd1,
    COOL      = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        mem_req_q, mem_req_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic        ins_valid_q, ins_valid_d;
  logic [31:0] ins_q, ins_d;
  logic [31:0] ins_pc_q, ins_pc_d;
  logic [LINES-1:0] valid_q;
  logic        fill;

  logic [TAG_BITS-1:0] tag_arr  [LINES];
  logic [31:0]         data_arr [LINES];

  logic [INDEX_BITS-1:0] idx, fill_idx;
  logic [TAG_BITS-1:0]   tag, fill_tag;
  logic                  hit;

  assign idx      = pc_q[INDEX_BITS+1:2];
  assign tag      = pc_q[31:INDEX_BITS+2];
  // The fill targets the requested address, not the pc, which a jump may already have moved.
  assign fill_idx = mem_addr_q[INDEX_BITS+1:2];
  assign fill_tag = mem_addr_q[31:INDEX_BITS+2];
  assign hit      = valid_q[idx] && (tag_arr[idx] == tag);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    ins_valid_d = 1'b0;
    ins_d       = ins_q;
    ins_pc_d    = ins_pc_q;
    fill        = 1'b0;
    case (state_q)
      LOOKUP: begin
        if (jump_en) begin
          pc_d = jump_pc;
        end else if (hit) begin
          if (!stall_in) begin
            ins_valid_d = 1'b1;
            ins_d       = data_arr[idx];
            ins_pc_d    = pc_q;
            pc_d        = pc_q + 32'd4;
          end
        end else begin
          mem_req_d  = 1'b1;
          mem_addr_d = pc_q;
          state_d    = MISS_WAIT;
        end
      end
      MISS_WAIT: begin
        if (mem_ok) begin
          fill      = 1'b1;
          mem_req_d = 1'b0;
          state_d   = COOL;
          if (jump_en) pc_d = jump_pc;
        end else if (jump_en) begin
          mem_req_d = 1'b0;
          pc_d      = jump_pc;
          state_d   = COOL;
        end
      end
      COOL: begin
        if (jump_en) pc_d = jump_pc;
        state_d = LOOKUP;
      end
      default: state_d = LOOKUP;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LOOKUP;
      pc_q        <= RESET_PC;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= 32'h0;
      ins_valid_q <= 1'b0;
      ins_q       <= 32'h0;
      ins_pc_q    <= 32'h0;
      valid_q     <= '0;
    end else if (rdy) begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      ins_valid_q <= ins_valid_d;
      ins_q       <= ins_d;
      ins_pc_q    <= ins_pc_d;
      if (fill) valid_q[fill_idx] <= 1'b1;
    end
  end

  // Tag/data storage carries no reset; the valid bits alone qualify it.
  always_ff @(posedge clk) begin
    if (rdy && fill) begin
      tag_arr[fill_idx]  <= fill_tag;
      data_arr[fill_idx] <= mem_ins;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;
  assign ins_valid = ins_valid_q;
  assign ins       = ins_q;
  assign ins_pc    = ins_pc_q;

endmodule

// File: tb/tb_ins_fetch_cache.sv
// tb/tb_ins_fetch_cache.sv - scoreboard bench for ins_fetch_cache.
module tb_ins_fetch_cache;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rdy = 1'b1;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ok = 1'b0;
  logic [31:0] mem_ins = 32'h0;
  logic        stall_in = 1'b0;
  logic        jump_en = 1'b0;
  logic [31:0] jump_pc = 32'h0;
  logic        ins_valid;
  logic [31:0] ins;
  logic [31:0] ins_pc;

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] sb [$];

  ins_fetch_cache #(.INDEX_BITS(6), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ok(mem_ok), .mem_ins(mem_ins),
    .stall_in(stall_in), .jump_en(jump_en), .jump_pc(jump_pc),
    .ins_valid(ins_valid), .ins(ins), .ins_pc(ins_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memw(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h0000_0013;
      32'h4:   return 32'h0010_0093;
      default: return {16'hA5A5, a[15:0]};
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_ins(input logic [31:0] a);
    sb.push_back({memw(a), a});
  endtask

  // Monitor: every emitted instruction must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && ins_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_ins_pc", ins_pc, 32'hFFFF_FFFF);
      end else begin
        logic [63:0] e;
        e = sb.pop_front();
        chk("ins", ins, e[63:32]);
        chk("ins_pc", ins_pc, e[31:0]);
      end
    end
  end

  task automatic wait_req(input logic [31:0] a);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mem_req && n < 50);
    chk("mem_req_seen", {31'h0, mem_req}, 32'h1);
    chk("mem_addr", mem_addr, a);
  endtask

  task automatic serve(input logic [31:0] a, input logic jmp, input logic [31:0] jpc);
    wait_req(a);
    mem_ok  = 1'b1;
    mem_ins = memw(a);
    jump_en = jmp;
    jump_pc = jpc;
    if (!jmp) expect_ins(a);
    @(negedge clk);
    mem_ok  = 1'b0;
    jump_en = 1'b0;
    chk("req_drop", {31'h0, mem_req}, 32'h0);
    if (!jmp) begin
      @(negedge clk);
      chk("cool_no_emit", {31'h0, ins_valid}, 32'h0);
      @(negedge clk);
      chk("miss_emit_lat", {31'h0, ins_valid}, 32'h1);
    end
  endtask

  task automatic jump_in_wait(input logic [31:0] a, input logic [31:0] jpc);
    wait_req(a);
    jump_en = 1'b1;
    jump_pc = jpc;
    @(negedge clk);
    jump_en = 1'b0;
    chk("jump_req_drop", {31'h0, mem_req}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    chk("rst_mem_req", {31'h0, mem_req}, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_ins_valid", {31'h0, ins_valid}, 32'h0);
    chk("rst_ins", ins, 32'h0);
    chk("rst_ins_pc", ins_pc, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Cold misses at 0 and 4, then abandon the miss at 8.
    serve(32'h0, 1'b0, 32'h0);
    serve(32'h4, 1'b0, 32'h0);
    jump_in_wait(32'h8, 32'h100);
    @(negedge clk);
    chk("cool_req_low", {31'h0, mem_req}, 32'h0);
    wait_req(32'h100);

    // Fill 0x100 while jumping to 0x40; then come back to 0x100 and expect a hit.
    serve(32'h100, 1'b1, 32'h40);
    jump_in_wait(32'h40, 32'h100);
    expect_ins(32'h100);
    @(negedge clk);
    chk("refill_no_req_a", {31'h0, mem_req}, 32'h0);
    @(negedge clk);
    chk("refill_no_req_b", {31'h0, mem_req}, 32'h0);
    chk("refill_hit", {31'h0, ins_valid}, 32'h1);

    // Conflict: 0x100 evicted 0, so 0 misses again; 4 still hits.
    jump_in_wait(32'h104, 32'h0);
    serve(32'h0, 1'b0, 32'h0);
    expect_ins(32'h4);
    serve(32'h8, 1'b0, 32'h0);
    serve(32'hC, 1'b0, 32'h0);

    // Back to 0 with downstream stalled.
    wait_req(32'h10);
    jump_en  = 1'b1;
    jump_pc  = 32'h0;
    stall_in = 1'b1;
    @(negedge clk);
    jump_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stall_no_emit", {31'h0, ins_valid}, 32'h0);
    end
    stall_in = 1'b0;
    for (int i = 0; i < 4; i++) expect_ins(32'(i * 4));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("loop_consec", {31'h0, ins_valid}, 32'h1);
    end

    // Conflict refill of 0x100 with a rdy freeze mid-wait.
    jump_in_wait(32'h10, 32'h100);
    wait_req(32'h100);
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("frz_mem_req", {31'h0, mem_req}, 32'h1);
      chk("frz_mem_addr", mem_addr, 32'h100);
    end
    rdy = 1'b1;
    serve(32'h100, 1'b0, 32'h0);
    jump_in_wait(32'h104, 32'h0);
    serve(32'h0, 1'b0, 32'h0);
    expect_ins(32'h4);
    expect_ins(32'h8);
    expect_ins(32'hC);
    wait_req(32'h10);
    repeat (3) @(negedge clk);
    chk("sb_drain", sb.size(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
